exp_unit: RTL
=============

EXP_UNIT -- requirements
Module: exp_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter LATENCY, default 20, meaning the cycles from accepted start to the done pulse; legal range 6..31.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: exp_en from the control unit, a level request.
REQ-006 The block SHALL have port base, input, WIDTH bits: the operand Val_Rn.
REQ-007 The block SHALL have port power, input, 5 bits: the unsigned exponent.
REQ-008 The block SHALL have port busy, output, 1 bit: a computation is in progress.
REQ-009 The block SHALL have port ready, output, 1 bit: equal to ~busy, the stall release for the pipeline.
REQ-010 The block SHALL have port done, output, 1 bit: a single-cycle pulse when result becomes valid.
REQ-011 The block SHALL have port result, output, WIDTH bits: base^power mod 2^WIDTH.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, encoded in the shared package.
REQ-013 In IDLE with start=1, the block SHALL latch base and power, set acc=1, sq=base and cnt=0, then enter RUN; the cycle in which start is sampled is cycle 0.
REQ-014 start SHALL be sampled only in IDLE; start held high during RUN or DONE SHALL be ignored, with no restart and no queueing.
REQ-015 RUN SHALL perform LSB-first square-and-multiply, one exponent bit per cycle, for cycles with cnt<5: if power[cnt]=1 then acc<=acc*sq (low WIDTH bits); sq<=sq*sq (low WIDTH bits).
REQ-016 For cycles with cnt>=5, RUN SHALL hold acc and sq unchanged as padding, so latency is fixed and independent of operands.
REQ-017 cnt SHALL increment every RUN cycle; RUN SHALL exit to DONE when cnt==LATENCY-2.
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE; ready SHALL be 0 for exactly LATENCY cycles, namely cycles 1..LATENCY.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle (cycle LATENCY), result SHALL equal acc, and the next state SHALL be IDLE.
REQ-020 result SHALL hold its value after DONE until the next DONE or reset.
REQ-021 power=0 SHALL yield result 1 for any base, including base=0.
REQ-022 Overflow SHALL wrap modulo 2^WIDTH, with no saturation and no flag.
REQ-023 base and power changing after cycle 0 SHALL NOT affect the computation.
REQ-024 start=1 in the same cycle as DONE SHALL be ignored; a new request SHALL be accepted no earlier than cycle LATENCY+1, in IDLE.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, acc=0, sq=0, cnt=0, result=0, done=0, busy=0, ready=1.
REQ-026 rst SHALL take priority over start and over every FSM transition.
REQ-027 rst asserted mid-RUN SHALL abort the computation with no done pulse; result SHALL read 0 afterwards.

Structure
REQ-028 Package exp_pkg SHALL hold the state enum, the default WIDTH and LATENCY constants, and the constant EXP_BITS=5.
REQ-029 Sub-module exp_mul SHALL be a combinational WIDTHxWIDTH multiplier returning the low WIDTH bits.
REQ-030 Two exp_mul instances SHALL be used: one for acc*sq and one for sq*sq.

Verification
REQ-031 Bench: base=3, power=4, start pulse at cycle 0 -> done=1 at cycle 20 only, result=81, ready=0 during cycles 1..20.
REQ-032 Bench: base=5, power=13 -> result=1220703125 (0x48C27395); base=2, power=31 -> result=0x80000000.
REQ-033 Bench: base=0xFFFFFFFF with power=3 -> result=0xFFFFFFFF; with power=2 -> result=1; base=0, power=0 -> result=1.
REQ-034 Bench: start held high for 25 cycles with base=2, power=3 -> exactly one done pulse at cycle 20, result=8; second acceptance at cycle 21 -> done at cycle 41.
REQ-035 Bench: rst at cycle 7 of a base=3, power=4 run -> no done pulse, result=0, ready=1 from cycle 8; a new start then completes normally with result 81.
REQ-036 Bench: change base and power to random values every cycle during RUN -> result equals the value computed from the operands latched at cycle 0.

Source files
------------

// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared constants and FSM encoding for the exponentiation unit
package exp_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_LATENCY = 20;
    localparam int EXP_BITS    = 5;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } exp_state_e;

endpackage

// File: rtl/exp_mul.sv
// rtl/exp_mul.sv - combinational WIDTHxWIDTH multiplier keeping the low WIDTH bits
module exp_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o
);

    // Result context is WIDTH bits, so the product wraps modulo 2^WIDTH.
    assign p_o = a_i * b_i;

endmodule

// File: rtl/exp_unit.sv
// rtl/exp_unit.sv - fixed-latency base^power mod 2^WIDTH, LSB-first square-and-multiply
module exp_unit
    import exp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    base,
    input  logic [EXP_BITS-1:0] power,
    output logic                busy,
    output logic                ready,
    output logic                done,
    output logic [WIDTH-1:0]    result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

    exp_state_e          state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    sq_q, sq_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EXP_BITS-1:0] power_q, power_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [WIDTH-1:0]    acc_sq;
    logic [WIDTH-1:0]    sq_sq;

    exp_mul #(.WIDTH(WIDTH)) u_mul_acc (
        .a_i (acc_q),
        .b_i (sq_q),
        .p_o (acc_sq)
    );

    exp_mul #(.WIDTH(WIDTH)) u_mul_sq (
        .a_i (sq_q),
        .b_i (sq_q),
        .p_o (sq_sq)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sq_d     = sq_q;
        cnt_d    = cnt_q;
        power_d  = power_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    power_d = power;
                    acc_d   = WIDTH'(1);
                    sq_d    = base;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Past the exponent bits the datapath idles so latency never depends on operands.
                if (cnt_q < CNT_W'(EXP_BITS)) begin
                    if (power_q[cnt_q[2:0]]) begin
                        acc_d = acc_sq;
                    end
                    sq_d = sq_sq;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = acc_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sq_q     <= '0;
            cnt_q    <= '0;
            power_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            cnt_q    <= cnt_d;
            power_q  <= power_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign ready  = ~busy;
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
